// File: rtl/mips_mem_responder.sv
// Single-port word memory that answers MIPS fetch and load/store requests with a configurable delay.
// Optional MEM_RAND_DELAY_EN adds an LFSR-driven 0..3 cycle jitter on top of LATENCY.
module mips_mem_responder #(
   parameter int ADDR_WIDTH = 10,
   parameter int LATENCY    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] PC,
   input  logic        Inst_Req_Valid,
   output logic        Inst_Req_Ack,
   output logic [31:0] Instruction,
   output logic        Inst_Valid,
   input  logic        Inst_Ack,
   input  logic [31:0] Address,
   input  logic        MemWrite,
   input  logic [31:0] Write_data,
   input  logic [3:0]  Write_strb,
   input  logic        MemRead,
   output logic        Mem_Req_Ack,
   output logic [31:0] Read_data,
   output logic        Read_data_Valid,
   input  logic        Read_data_Ack
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   localparam logic [4:0] LAT5 = 5'(LATENCY);

   state_t                state, state_nxt;
   logic                  typ;          // 1: data response, 0: instruction response
   logic [3:0]            cnt;
   logic [31:0]           cap;
   logic [31:0]           mem [2**ADDR_WIDTH];
   logic [ADDR_WIDTH-1:0] d_idx, i_idx;
   logic                  wr_acc, rd_acc, acc, resp_ack;
   logic [31:0]           rd_word;
   logic [3:0]            dly;
   logic                  unused_bits;

   assign d_idx       = Address[ADDR_WIDTH+1:2];
   assign i_idx       = PC[ADDR_WIDTH+1:2];
   assign unused_bits = ^{Address[31:ADDR_WIDTH+2], Address[1:0], PC[31:ADDR_WIDTH+2], PC[1:0]};

   assign wr_acc   = Mem_Req_Ack & MemWrite;
   assign rd_acc   = Mem_Req_Ack & ~MemWrite;
   assign acc      = rd_acc | Inst_Req_Ack;
   assign rd_word  = rd_acc ? mem[d_idx] : mem[i_idx];
   assign resp_ack = typ ? Read_data_Ack : Inst_Ack;

`ifdef MEM_RAND_DELAY_EN
   logic [7:0] lfsr;
   logic [4:0] dsum;

   assign dsum = LAT5 + {3'b000, lfsr[1:0]};
   assign dly  = (dsum > 5'd15) ? 4'd15 : dsum[3:0];

   always_ff @(posedge clk) begin
      if (rst)      lfsr <= 8'hA5;
      else if (acc) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   end
`else
   assign dly = LAT5[3:0];
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= 4'd0;
         typ         <= 1'b0;
         cap         <= 32'd0;
         Instruction <= 32'd0;
         Read_data   <= 32'd0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: if (acc) begin
               typ <= rd_acc;
               cnt <= dly;
               cap <= rd_word;
               // zero delay skips WAIT, so the output register loads straight from the array
               if (dly == 4'd0) begin
                  if (rd_acc) Read_data   <= rd_word;
                  else        Instruction <= rd_word;
               end
            end
            WAIT: begin
               cnt <= cnt - 4'd1;
               if (state_nxt == RESP) begin
                  if (typ) Read_data   <= cap;
                  else     Instruction <= cap;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && wr_acc)
         for (int b = 0; b < 4; b++)
            if (Write_strb[b]) mem[d_idx][8*b +: 8] <= Write_data[8*b +: 8];
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (acc) state_nxt = (dly == 4'd0) ? RESP : WAIT;
         WAIT:    if (cnt <= 4'd1) state_nxt = RESP;
         RESP:    if (resp_ack) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      Mem_Req_Ack     = 1'b0;
      Inst_Req_Ack    = 1'b0;
      Inst_Valid      = 1'b0;
      Read_data_Valid = 1'b0;
      case (state)
         IDLE: begin
            Mem_Req_Ack  = MemRead | MemWrite;
            Inst_Req_Ack = Inst_Req_Valid & ~(MemRead | MemWrite);
         end
         RESP: begin
            Read_data_Valid = typ;
            Inst_Valid      = ~typ;
         end
         default: ;
      endcase
   end

endmodule

// File: doc/mips_mem_responder.md
MIPS_MEM_RESPONDER -- requirements
Module: mips_mem_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, SHALL set the word-address width; array depth is 2^ADDR_WIDTH 32-bit words.
REQ-002 Parameter LATENCY, default 2, range 0..15, SHALL set the base read-response delay in cycles.
REQ-003 clk  in  1  clock; all state SHALL update on the rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 PC  in  32  instruction fetch byte address; Inst_Req_Valid  in  1  fetch request; Inst_Req_Ack  out  1  fetch accepted.
REQ-006 Instruction  out  32  fetched word; Inst_Valid  out  1  fetch response valid; Inst_Ack  in  1  CPU takes response.
REQ-007 Address  in  32  data byte address (word-aligned); MemWrite  in  1; Write_data  in  32; Write_strb  in  4; MemRead  in  1; Mem_Req_Ack  out  1  data request accepted.
REQ-008 Read_data  out  32  loaded word; Read_data_Valid  out  1; Read_data_Ack  in  1  CPU takes load data.

Function
REQ-009 The block SHALL implement one FSM with states IDLE, WAIT and RESP, and a 1-bit response-type flag (INST or DATA).
REQ-010 In IDLE, Mem_Req_Ack SHALL be combinationally 1 when MemRead or MemWrite is 1; the block SHALL accept in that same cycle.
REQ-011 In IDLE, Inst_Req_Ack SHALL be combinationally 1 when Inst_Req_Valid is 1 and neither MemRead nor MemWrite is 1; data requests take priority.
REQ-012 Both request acks SHALL be 0 in WAIT and RESP.
REQ-013 On an accepted write, the block SHALL update word Address[ADDR_WIDTH+1:2] at the accepting edge, byte lane i only where Write_strb[i]=1.
REQ-014 After an accepted write, the FSM SHALL stay in IDLE and SHALL produce no response.
REQ-015 If MemRead and MemWrite are both 1, the request SHALL be treated as a write only.
REQ-016 On an accepted read or fetch, the block SHALL capture the array word at the accepting edge.
REQ-017 The read index SHALL be Address[ADDR_WIDTH+1:2] for data and PC[ADDR_WIDTH+1:2] for fetches; higher address bits SHALL be ignored, so addresses wrap.
REQ-018 After an accepted read or fetch, the FSM SHALL load a 4-bit down-counter with the effective delay D.
REQ-019 If D>0 the FSM SHALL go to WAIT; if D=0 it SHALL go directly to RESP.
REQ-020 In WAIT, the counter SHALL decrement each cycle, and the FSM SHALL enter RESP on the edge where the counter reaches 0.
REQ-021 If acceptance is at cycle T, Inst_Valid or Read_data_Valid SHALL first be 1 in cycle T+1+D.
REQ-022 In RESP, only the valid matching the type flag SHALL be 1, and Instruction or Read_data SHALL hold the captured word stable.
REQ-023 In RESP, valid SHALL remain 1 until the matching Inst_Ack or Read_data_Ack is 1; the FSM SHALL then return to IDLE on that edge.
REQ-024 A new request SHALL be acceptable in the cycle after the response handshake.
REQ-025 The non-matching ack input SHALL be ignored in RESP.
REQ-026 Request inputs SHALL be ignored outside IDLE; the requester holds them per protocol.
REQ-027 Instruction and Read_data SHALL be registered and SHALL keep their last value outside RESP.

Reset
REQ-028 When rst=1 at an edge, the FSM SHALL enter IDLE and the counter and type flag SHALL clear.
REQ-029 After reset, Instruction and Read_data SHALL be 0, and Inst_Valid and Read_data_Valid SHALL be 0.
REQ-030 Any in-flight read, fetch or pending response SHALL be discarded by reset.
REQ-031 Array contents SHALL NOT be altered by reset.
REQ-032 Reset SHALL take priority over any simultaneous handshake.

Configuration
REQ-033 Macro MEM_RAND_DELAY_EN defined: an 8-bit Fibonacci LFSR (taps 8,6,5,4) SHALL be used, reset to 8'hA5, stepping once per accepted read or fetch.
REQ-034 With MEM_RAND_DELAY_EN defined, D SHALL be LATENCY + lfsr[1:0], using the pre-step value and saturating at 15.
REQ-035 Macro MEM_RAND_DELAY_EN undefined: no LFSR SHALL exist, and D SHALL be LATENCY.

Verification
REQ-036 Check: after reset, all outputs are 0; drive Inst_Req_Valid=1 -> Inst_Req_Ack=1 in the same cycle.
REQ-037 Check: LATENCY=2, word 3 preloaded 32'h2402_0005, fetch PC=0xC accepted at cycle T -> Inst_Valid=1 from T+3 with Instruction=32'h2402_0005, held while Inst_Ack=0 for 4 cycles, then IDLE.
REQ-038 Check: write Address=0x10, Write_strb=4'b0110, Write_data=32'hAABBCCDD over old 32'h11223344, then MemRead 0x10 -> Read_data=32'h11BBCC44.
REQ-039 Check: MemRead and Inst_Req_Valid together in IDLE -> only Mem_Req_Ack=1; the fetch is acked only after the Read_data handshake.
REQ-040 Check: LATENCY=0 -> valid at T+1; with ADDR_WIDTH=10, Address=0x1000 -> reads word 0 (wrap).
REQ-041 Check: rst pulsed during WAIT -> valid never asserts, and the next fetch is acked in IDLE; with MEM_RAND_DELAY_EN, the first read delay is LATENCY+1.
